// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states,
// RV32 opcode constants, ALU operation and PC source codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU-operation decoder; flags unknown opcodes and unsupported
// funct3 values on ALU instructions as illegal. Zero latency, no flow control.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       ins30,
  output logic [2:0] ALUop,
  output logic       illegal
);

  always_comb begin
    ALUop   = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_R, OP_IALU: begin
        case (funct3)
          3'b111:  ALUop = ALU_AND;
          3'b110:  ALUop = ALU_OR;
          3'b010:  ALUop = ALU_SLT;
          // Only register-register add becomes sub; for addi bit 30 is immediate.
          3'b000:  ALUop = ((opcode == OP_R) && ins30) ? ALU_SUB : ALU_ADD;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_JAL: ALUop = ALU_ADD;
      OP_BEQ:               ALUop = ALU_SUB;
      default:              illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32 subset controller (BEQ 3, R/I/SW/JAL 4, LW 5 cycles); each mem_ready-low
// cycle stalls one cycle, MEM_WAIT_MAX stalls trap. MC_CTRL_PERF_EN adds cycle/retire counters.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Mem2Reg,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  ALUop,
  output logic [1:0]  PCSrc
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
`endif
);

  localparam int WW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

  state_t       state, state_nxt;
  logic [6:0]   opcode_q;
  logic [2:0]   funct3_q;
  logic         ins30_q;
  logic [WW-1:0] wait_cnt;

  logic [6:0]   dec_op;
  logic [2:0]   dec_f3;
  logic         dec_i30;
  logic [2:0]   dec_aluop;
  logic         dec_illegal;
  logic         wait_last;
  logic         is_ialu, is_lw, is_sw, is_beq, is_jal;
  logic         unused_ins;

  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  // The instruction word is only valid during DECODE; afterwards use the latched copy.
  assign dec_op  = (state == DECODE) ? ins[6:0]   : opcode_q;
  assign dec_f3  = (state == DECODE) ? ins[14:12] : funct3_q;
  assign dec_i30 = (state == DECODE) ? ins[30]    : ins30_q;

  mc_alu_dec u_alu_dec (
    .opcode  (dec_op),
    .funct3  (dec_f3),
    .ins30   (dec_i30),
    .ALUop   (dec_aluop),
    .illegal (dec_illegal)
  );

  assign is_ialu   = (opcode_q == OP_IALU);
  assign is_lw     = (opcode_q == OP_LW);
  assign is_sw     = (opcode_q == OP_SW);
  assign is_beq    = (opcode_q == OP_BEQ);
  assign is_jal    = (opcode_q == OP_JAL);
  assign wait_last = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      funct3_q <= '0;
      ins30_q  <= 1'b0;
    end else if (state == DECODE) begin
      opcode_q <= ins[6:0];
      funct3_q <= ins[14:12];
      ins30_q  <= ins[30];
    end
  end

  // Counts consecutive stalled cycles; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (((state == FETCH) || (state == MEM)) && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Mem2Reg   = 1'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    ALUop     = ALU_AND;
    PCSrc     = PC_SEQ;
    // Outputs are forced low for as long as reset is held, not just after an edge.
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          IRWrite = mem_ready;
          if (mem_ready)      state_nxt = DECODE;
          else if (wait_last) state_nxt = TRAP;
        end
        DECODE: begin
          state_nxt = dec_illegal ? TRAP : EXEC;
        end
        EXEC: begin
          ALUop  = dec_aluop;
          ALUSrc = is_ialu || is_lw || is_sw;
          if (is_beq) begin
            PCWrite   = 1'b1;
            retire    = 1'b1;
            PCSrc     = zero ? PC_BRANCH : PC_SEQ;
            state_nxt = FETCH;
          end else if (is_mem_op(opcode_q)) begin
            state_nxt = MEM;
          end else begin
            state_nxt = WB;
          end
        end
        MEM: begin
          mem_req  = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
          if (mem_ready) begin
            if (is_sw) begin
              PCWrite   = 1'b1;
              retire    = 1'b1;
              state_nxt = FETCH;
            end else begin
              state_nxt = WB;
            end
          end else if (wait_last) begin
            state_nxt = TRAP;
          end
        end
        WB: begin
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
          retire    = 1'b1;
          Mem2Reg   = is_lw;
          PCSrc     = is_jal ? PC_JUMP : PC_SEQ;
          state_nxt = FETCH;
        end
        TRAP: begin
          trap = 1'b1;
        end
        default: begin
          state_nxt = TRAP;
        end
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (state != TRAP) cycle_cnt  <= cycle_cnt + 32'd1;
      if (retire)        retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a timeline model of each instruction pushes expected
// per-cycle outputs; a negedge monitor pops and compares. Also checks counters under MC_CTRL_PERF_EN.
module tb_mc_ctrl;

  localparam int WMAX = 15;

  localparam int PH_RST   = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_DEC   = 2;
  localparam int PH_EXEC  = 3;
  localparam int PH_MEM   = 4;
  localparam int PH_WB    = 5;
  localparam int PH_TRAP  = 6;

  localparam logic [31:0] ADD_I = 32'h002081B3;
  localparam logic [31:0] LW_I  = 32'h0000A183;
  localparam logic [31:0] BEQ_I = 32'h00208463;
  localparam logic [31:0] SW_I  = 32'h0020A023;
  localparam logic [31:0] JAL_I = 32'h0000006F;
  localparam logic [31:0] BAD_I = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, IRWrite, PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, retire, trap;
  logic [2:0]  ALUop;
  logic [1:0]  PCSrc;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ins       (ins),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ALUSrc    (ALUSrc),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Mem2Reg   (Mem2Reg),
    .retire    (retire),
    .trap      (trap),
    .ALUop     (ALUop),
    .PCSrc     (PCSrc)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt (cycle_cnt),
    .retire_cnt(retire_cnt)
`endif
  );

  typedef struct packed {
    logic       mem_req, ir, pcw, rw, alusrc, mrd, mwr, m2r, ret, trap;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } ovec_t;

  typedef struct {
    ovec_t       exp;
    ovec_t       msk;
    int unsigned cyc;
    int unsigned ret;
    int          ph;
  } sb_t;

  sb_t         sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc_m = 0;
  int unsigned ret_m = 0;

  function automatic string ph_name(input int ph);
    case (ph)
      PH_RST:   return "reset";
      PH_FETCH: return "fetch";
      PH_DEC:   return "decode";
      PH_EXEC:  return "exec";
      PH_MEM:   return "mem";
      PH_WB:    return "wb";
      PH_TRAP:  return "trap";
      default:  return "unknown";
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    if (op == 7'b0110011 || op == 7'b0010011)
      return (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010) || (f3 == 3'b000);
    return (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b1100011) || (op == 7'b1101111);
  endfunction

  function automatic logic [2:0] ref_alu(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    if (op == 7'b1100011) return 3'b110;
    if (op == 7'b0000011 || op == 7'b0100011) return 3'b010;
    case (i[14:12])
      3'b111:  return 3'b000;
      3'b110:  return 3'b001;
      3'b010:  return 3'b111;
      default: return (op == 7'b0110011 && i[30]) ? 3'b110 : 3'b010;
    endcase
  endfunction

  function automatic void ref_out(input int ph, input logic [31:0] i, input logic z,
                                  input logic rdy, output ovec_t e, output ovec_t m);
    logic [6:0] op;
    logic lw, sw, jal, beq, ialu;
    op   = i[6:0];
    lw   = (op == 7'b0000011);
    sw   = (op == 7'b0100011);
    jal  = (op == 7'b1101111);
    beq  = (op == 7'b1100011);
    ialu = (op == 7'b0010011);
    e = '0;
    m = '1;
    case (ph)
      PH_FETCH: begin e.mem_req = 1'b1; e.mrd = 1'b1; e.ir = rdy; end
      PH_EXEC: begin
        e.aluop  = ref_alu(i);
        e.alusrc = ialu | lw | sw;
        if (beq) begin e.pcw = 1'b1; e.ret = 1'b1; e.pcsrc = z ? 2'b01 : 2'b00; end
      end
      PH_MEM: begin
        e.mem_req = 1'b1; e.mrd = lw; e.mwr = sw;
        if (sw && rdy) begin e.pcw = 1'b1; e.ret = 1'b1; e.pcsrc = 2'b00; end
      end
      PH_WB: begin
        e.rw = 1'b1; e.pcw = 1'b1; e.ret = 1'b1; e.m2r = lw;
        e.pcsrc = jal ? 2'b10 : 2'b00;
      end
      PH_TRAP: e.trap = 1'b1;
      default: ;
    endcase
    // Fields whose value is undefined in a given cycle are not compared (all are during reset).
    if (ph != PH_RST) begin
      if (!(ph == PH_EXEC && !jal)) m.aluop = '0;
      if (!e.pcw)                   m.pcsrc = '0;
      if (ph != PH_EXEC)            m.alusrc = 1'b0;
      if (ph != PH_WB)              m.m2r = 1'b0;
    end
  endfunction

  task automatic step(input int ph, input logic rst, input logic rdy,
                      input logic [31:0] drv, input logic [31:0] cur, input logic z);
    sb_t s;
    ovec_t e, m;
    @(posedge clk);
    #1;
    rst_n     = rst;
    mem_ready = rdy;
    ins       = drv;
    zero      = z;
    ref_out(ph, cur, z, rdy, e, m);
    if (!rst) begin cyc_m = 0; ret_m = 0; end
    s.exp = e; s.msk = m; s.cyc = cyc_m; s.ret = ret_m; s.ph = ph;
    sbq.push_back(s);
    if (rst && !e.trap) cyc_m++;
    if (rst && e.ret)   ret_m++;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(PH_RST, 1'b0, rb(), $urandom, 32'h0, rb());
  endtask

  task automatic trap_run(input int n);
    for (int k = 0; k < n; k++) step(PH_TRAP, 1'b1, rb(), $urandom, 32'h0, rb());
  endtask

  task automatic run_instr(input logic [31:0] i, input int wf, input int wm,
                           input logic z, output logic trapped);
    logic [6:0] op;
    op = i[6:0];
    trapped = 1'b0;
    for (int k = 0; k < wf && k < WMAX; k++) step(PH_FETCH, 1'b1, 1'b0, $urandom, i, rb());
    if (wf >= WMAX) begin trap_run(20); trapped = 1'b1; return; end
    step(PH_FETCH, 1'b1, 1'b1, $urandom, i, rb());
    step(PH_DEC, 1'b1, rb(), i, i, rb());
    if (!legal(i)) begin trap_run(20); trapped = 1'b1; return; end
    step(PH_EXEC, 1'b1, rb(), $urandom, i, z);
    if (op == 7'b1100011) return;
    if (op == 7'b0000011 || op == 7'b0100011) begin
      for (int k = 0; k < wm && k < WMAX; k++) step(PH_MEM, 1'b1, 1'b0, $urandom, i, rb());
      if (wm >= WMAX) begin trap_run(20); trapped = 1'b1; return; end
      step(PH_MEM, 1'b1, 1'b1, $urandom, i, rb());
      if (op == 7'b0100011) return;
    end
    step(PH_WB, 1'b1, rb(), $urandom, i, rb());
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    logic [2:0]  lf3 [4];
    logic [2:0]  bf3 [4];
    logic [6:0]  bop [6];
    int          sel;
    lf3 = '{3'b111, 3'b110, 3'b010, 3'b000};
    bf3 = '{3'b001, 3'b011, 3'b100, 3'b101};
    bop = '{7'h7F, 7'h37, 7'h17, 7'h67, 7'h73, 7'h00};
    r   = $urandom;
    sel = int'($urandom_range(0, 19));
    if (sel < 5)       begin r[6:0] = 7'b0110011; r[14:12] = lf3[$urandom_range(0, 3)]; end
    else if (sel < 9)  begin r[6:0] = 7'b0010011; r[14:12] = lf3[$urandom_range(0, 3)]; end
    else if (sel < 11) r[6:0] = 7'b0000011;
    else if (sel < 13) r[6:0] = 7'b0100011;
    else if (sel < 16) r[6:0] = 7'b1100011;
    else if (sel < 18) r[6:0] = 7'b1101111;
    else if (sel == 18) begin
      r[6:0]   = rb() ? 7'b0110011 : 7'b0010011;
      r[14:12] = bf3[$urandom_range(0, 3)];
    end else r[6:0] = bop[$urandom_range(0, 5)];
    return r;
  endfunction

  function automatic int rwait();
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel == 0) return WMAX - 1;
    if (sel == 1) return WMAX;
    return int'($urandom_range(0, 3));
  endfunction

  sb_t         mon_s;
  logic [14:0] mon_a, mon_e, mon_m;

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_s = sbq.pop_front();
      mon_a = {mem_req, IRWrite, PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg,
               retire, trap, ALUop, PCSrc};
      mon_e = mon_s.exp;
      mon_m = mon_s.msk;
      n_vec++;
      if ((mon_a & mon_m) !== (mon_e & mon_m)) begin
        n_err++;
        $display("FAIL %s outputs: got %b required %b (compared bits %b) at %0t",
                 ph_name(mon_s.ph), mon_a, mon_e, mon_m, $time);
      end
`ifdef MC_CTRL_PERF_EN
      n_vec++;
      if (cycle_cnt !== 32'(mon_s.cyc)) begin
        n_err++;
        $display("FAIL %s cycle_cnt: got %0d required %0d at %0t",
                 ph_name(mon_s.ph), cycle_cnt, mon_s.cyc, $time);
      end
      n_vec++;
      if (retire_cnt !== 32'(mon_s.ret)) begin
        n_err++;
        $display("FAIL %s retire_cnt: got %0d required %0d at %0t",
                 ph_name(mon_s.ph), retire_cnt, mon_s.ret, $time);
      end
`endif
    end
  end

  initial begin
    logic t;
    rst_n     = 1'b0;
    ins       = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    do_reset(2);

    run_instr(ADD_I, 0, 0, rb(), t);
    run_instr(LW_I, 0, 3, rb(), t);
    run_instr(BEQ_I, 0, 0, 1'b1, t);
    run_instr(BEQ_I, 0, 0, 1'b0, t);
    run_instr(SW_I, 2, 1, rb(), t);
    run_instr(JAL_I, 1, 0, rb(), t);
    run_instr(ADD_I, WMAX - 1, 0, rb(), t);
    run_instr(LW_I, WMAX - 1, WMAX - 1, rb(), t);

    run_instr(BAD_I, 0, 0, rb(), t);
    do_reset(2);
    run_instr(ADD_I, WMAX, 0, rb(), t);
    do_reset(1);
    run_instr(LW_I, 0, WMAX, rb(), t);
    do_reset(2);

    step(PH_FETCH, 1'b1, 1'b1, $urandom, SW_I, rb());
    step(PH_DEC, 1'b1, rb(), SW_I, SW_I, rb());
    step(PH_EXEC, 1'b1, rb(), $urandom, SW_I, rb());
    step(PH_MEM, 1'b1, 1'b0, $urandom, SW_I, rb());
    step(PH_MEM, 1'b1, 1'b0, $urandom, SW_I, rb());
    do_reset(1);
    run_instr(ADD_I, 0, 0, rb(), t);

    for (int n = 0; n < 300; n++) begin
      run_instr(rand_ins(), rwait(), rwait(), rb(), t);
      if (t) do_reset(int'($urandom_range(1, 2)));
    end

    repeat (2) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: maximum wait cycles on mem_ready before a timeout trap.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ins  input  32  current instruction word, taken from the fetch memory output.
REQ-005 SHALL have port zero  input  1  ALU zero flag from the execute stage.
REQ-006 SHALL have port mem_ready  input  1  memory completion strobe for the current fetch or data access.
REQ-007 SHALL have these outputs, each 1 bit: mem_req (memory access active), IRWrite, PCWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, retire (1-cycle pulse), trap (sticky error).
REQ-008 SHALL have output ALUop, 3 bits: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-009 SHALL have output PCSrc, 2 bits: 00 PC+4, 01 branch target, 10 jump target.

Function
REQ-010 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and TRAP, held in a single registered state variable.
REQ-011 SHALL decode all outputs as Moore functions of the state and the latched opcode/funct fields.
REQ-012 In FETCH, SHALL assert mem_req=1 and MemRead=1 and hold them until mem_ready=1 at a clock edge; on that edge, SHALL assert IRWrite=1 for that cycle only and go to DECODE.
REQ-013 In DECODE, SHALL latch ins[6:0], ins[14:12] and ins[30].
REQ-014 DECODE SHALL go to EXEC for these opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW), 1100011 (BEQ), 1101111 (JAL).
REQ-015 Any other opcode SHALL send DECODE to TRAP.
REQ-016 ALUop mapping from funct3: 111 -> 000; 110 -> 001; 010 -> 111; 000 -> 010.
REQ-017 funct3=000 SHALL give 110 instead of 010 only when the opcode is R-type and ins[30]=1.
REQ-018 Any other funct3 with an R or I-ALU opcode SHALL go to TRAP.
REQ-019 In EXEC, ALUSrc SHALL be 1 for I-ALU, LW and SW, and 0 otherwise.
REQ-020 LW and SW SHALL use ALUop 010; BEQ SHALL use ALUop 110.
REQ-021 EXEC for BEQ SHALL assert PCWrite with PCSrc=01 if zero=1, or with PCSrc=00 if zero=0, then go to FETCH with retire=1.
REQ-022 EXEC for JAL SHALL go to WB.
REQ-023 EXEC for LW or SW SHALL go to MEM; all other instructions SHALL go to WB.
REQ-024 MEM SHALL assert mem_req with MemRead (LW) or MemWrite (SW) until mem_ready.
REQ-025 On mem_ready, LW SHALL go to WB; SW SHALL assert PCWrite with PCSrc=00, retire=1, and go to FETCH.
REQ-026 WB SHALL assert RegWrite and PCWrite, with Mem2Reg=1 only for LW.
REQ-027 WB SHALL drive PCSrc=10 for JAL and 00 otherwise, assert retire=1, and go to FETCH.
REQ-028 Latency with zero-wait memory, in cycles: BEQ 3; R, I-ALU and SW 4; JAL 4; LW 5. Each cycle of mem_ready low SHALL add exactly one cycle.
REQ-029 A wait counter SHALL count consecutive mem_ready=0 cycles in FETCH or MEM; on reaching MEM_WAIT_MAX, the FSM SHALL go to TRAP.
REQ-030 The wait counter SHALL clear on entry to each memory state.
REQ-031 mem_ready while mem_req=0 SHALL be ignored.
REQ-032 TRAP SHALL set trap=1 and hold every enable at 0 until reset.
REQ-033 PCWrite, RegWrite, MemWrite, IRWrite and retire SHALL never be asserted in the same cycle as trap=1.

Reset
REQ-034 rst_n=0 SHALL immediately force state FETCH, clear the wait counter and latched fields, and drive all outputs to 0, including mem_req, trap and retire.
REQ-035 In the first clock after rst_n rises, the FSM SHALL be in FETCH with mem_req=1.
REQ-036 Reset asserted mid-access SHALL abandon the access with no write-enable pulse.

Configuration
REQ-037 With MC_CTRL_PERF_EN defined, SHALL add 32-bit outputs cycle_cnt (increments each cycle outside reset and TRAP) and retire_cnt (increments on retire).
REQ-038 Both counters SHALL wrap modulo 2^32 and reset to 0.
REQ-039 Without MC_CTRL_PERF_EN, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-040 Package mc_ctrl_pkg SHALL hold the state enum, the opcode constants and the ALUop/PCSrc encodings.
REQ-041 ALUop decoding SHALL be a combinational sub-module mc_alu_dec (inputs opcode, funct3, ins30; outputs ALUop, illegal).

Verification
REQ-042 Bench SHALL cover: add x3,x1,x2 (0x002081B3), mem_ready always 1 -> states FETCH, DECODE, EXEC, WB; ALUop=010 in EXEC; RegWrite=1 and retire=1 in cycle 4.
REQ-043 Bench SHALL cover: lw (0x0000A183), mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles, Mem2Reg=1 in WB, total 8 cycles.
REQ-044 Bench SHALL cover: beq (0x00208463) with zero=1, then zero=0 -> PCSrc=01 then 00 in EXEC; retire in cycle 3; RegWrite never asserted.
REQ-045 Bench SHALL cover: opcode 0x7F -> trap=1 the cycle after DECODE; all enables stay 0 for 20 further cycles.
REQ-046 Bench SHALL cover: mem_ready held 0 in FETCH -> TRAP after exactly MEM_WAIT_MAX cycles.
REQ-047 Bench SHALL cover: rst_n pulsed low mid-MEM of sw -> MemWrite drops at once; FETCH with mem_req=1 after release; with MC_CTRL_PERF_EN, both counters read 0.
